// File: rtl/alu_commit_stage_pkg.sv
// Shared encodings for the ALU commit stage and its condition checker.
package alu_commit_stage_pkg;

    typedef enum logic [1:0] {
        OP_DATA = 2'd0,
        OP_MEM  = 2'd1,
        OP_BR   = 2'd2,
        OP_INV  = 2'd3
    } op_e;

    typedef enum logic [5:0] {
        CMD_AND = 6'd0,
        CMD_XOR = 6'd1,
        CMD_SUB = 6'd2,
        CMD_RSB = 6'd3,
        CMD_ADD = 6'd4,
        CMD_CMP = 6'd10,
        CMD_ORR = 6'd12
    } cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cmd_arith(input logic [5:0] cmd);
        return cmd == CMD_SUB || cmd == CMD_RSB ||
               cmd == CMD_ADD || cmd == CMD_CMP;
    endfunction

    function automatic logic cmd_logic(input logic [5:0] cmd);
        return cmd == CMD_AND || cmd == CMD_XOR || cmd == CMD_ORR;
    endfunction

endpackage

// File: rtl/alu_commit_stage_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV value.
module alu_commit_stage_cond_check
    import alu_commit_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = n == v;
            COND_LT: pass_o = n != v;
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_commit_stage.sv
// Execute-to-writeback stage: condition check, NZCV register, request
// generation and wrong-path squash after taken branches.
module alu_commit_stage
    import alu_commit_stage_pkg::*;
#(
    parameter int SQUASH_SLOTS = 2,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_cmd,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic [3:0]        in_rd,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flag,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic [3:0]        nzcv
);

    localparam logic [2:0] SLOTS = 3'(SQUASH_SLOTS);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              out_valid_q;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              br_q, br_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;

    logic pass, accept;
    logic is_data, is_mem, is_br;
    logic arith, logic_op, upd;

    alu_commit_stage_cond_check u_cond (
        .cond_i (in_cond),
        .nzcv_i (nzcv_q),
        .pass_o (pass)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign is_data  = in_op == OP_DATA;
    assign is_mem   = in_op == OP_MEM;
    assign is_br    = in_op == OP_BR;
    assign arith    = cmd_arith(in_cmd);
    assign logic_op = cmd_logic(in_cmd);
    assign upd      = pass && is_data && (in_s || in_cmd == CMD_CMP);

    always_comb begin
        nzcv_d = nzcv_q;
        if (upd && arith)
            nzcv_d = in_flag;
        else if (upd && logic_op)
            nzcv_d = {in_flag[FLAG_N], in_flag[FLAG_Z], nzcv_q[FLAG_C], nzcv_q[FLAG_V]};

        wb_en_d = pass && ((is_data && (logic_op || arith) && in_cmd != CMD_CMP)
                           || (is_mem && in_cmd[0]));
        wb_rd_d     = wb_en_d ? in_rd : 4'd0;
        wb_data_d   = (wb_en_d && is_data) ? in_result : '0;
        mem_en_d    = pass && is_mem;
        mem_we_d    = mem_en_d && !in_cmd[0];
        mem_addr_d  = mem_en_d ? in_result : '0;
        mem_wdata_d = mem_we_d ? in_store_data : '0;
        br_d        = pass && is_br;
        br_target_d = br_d ? in_result : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            nzcv_q      <= '0;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            br_q        <= 1'b0;
            br_target_q <= '0;
        end else if (accept && state_q == ST_SQUASH) begin
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            br_q        <= 1'b0;
            br_target_q <= '0;
            cnt_q       <= cnt_q - 3'd1;
            if (cnt_q <= 3'd1)
                state_q <= ST_RUN;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            nzcv_q      <= nzcv_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            br_q        <= br_d;
            br_target_q <= br_target_d;
            if (br_d) begin
                state_q <= ST_SQUASH;
                cnt_q   <= SLOTS;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            br_q        <= 1'b0;
            br_target_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign br_taken  = br_q;
    assign br_target = br_target_q;
    assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Directed bench for alu_commit_stage with hand-computed expectations.
module tb_alu_commit_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [5:0]  in_cmd;
    logic [3:0]  in_cond;
    logic        in_s;
    logic [3:0]  in_rd;
    logic [31:0] in_result;
    logic [3:0]  in_flag;
    logic [31:0] in_store_data;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic [3:0]  nzcv;

    int checks = 0;
    int errors = 0;

    alu_commit_stage #(.SQUASH_SLOTS(2), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_cmd        (in_cmd),
        .in_cond       (in_cond),
        .in_s          (in_s),
        .in_rd         (in_rd),
        .in_result     (in_result),
        .in_flag       (in_flag),
        .in_store_data (in_store_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .nzcv          (nzcv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] op, input logic [5:0] cmd,
                       input logic [3:0] cond, input logic s,
                       input logic [3:0] rd, input logic [31:0] res,
                       input logic [3:0] fl, input logic [31:0] sd);
        in_valid      = 1'b1;
        in_op         = op;
        in_cmd        = cmd;
        in_cond       = cond;
        in_s          = s;
        in_rd         = rd;
        in_result     = res;
        in_flag       = fl;
        in_store_data = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drv(2'd0, 6'd0, 4'hE, 1'b0, 4'd0, 32'd0, 4'h0, 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_nzcv", 32'(nzcv), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // ADDS r1 with flags 0011
        drv(2'd0, 6'd4, 4'hE, 1'b1, 4'd1, 32'h7, 4'b0011, 32'd0);
        tick();
        chk("adds_valid", 32'(out_valid), 32'd1);
        chk("adds_wb_en", 32'(wb_en), 32'd1);
        chk("adds_wb_data", wb_data, 32'h7);
        chk("adds_nzcv", 32'(nzcv), 32'b0011);

        // ANDS keeps C and V
        drv(2'd0, 6'd0, 4'hE, 1'b1, 4'd2, 32'h8000_0000, 4'b1000, 32'd0);
        tick();
        chk("ands_nzcv", 32'(nzcv), 32'b1011);
        chk("ands_wb_rd", 32'(wb_rd), 32'd2);
        chk("ands_wb_data", wb_data, 32'h8000_0000);

        // CMP then BEQ on the following cycle
        drv(2'd0, 6'd10, 4'hE, 1'b0, 4'd9, 32'h0, 4'b0110, 32'd0);
        tick();
        chk("cmp_nzcv", 32'(nzcv), 32'b0110);
        chk("cmp_wb_en", 32'(wb_en), 32'd0);
        chk("cmp_valid", 32'(out_valid), 32'd1);
        drv(2'd2, 6'd0, 4'h0, 1'b0, 4'd0, 32'h40, 4'b0000, 32'd0);
        tick();
        chk("beq_taken", 32'(br_taken), 32'd1);
        chk("beq_target", br_target, 32'h40);
        drv(2'd0, 6'd4, 4'hE, 1'b1, 4'd1, 32'h11, 4'b1111, 32'd0);
        tick();
        chk("sq1_valid", 32'(out_valid), 32'd0);
        chk("sq1_nzcv", 32'(nzcv), 32'b0110);
        drv(2'd0, 6'd2, 4'hE, 1'b1, 4'd2, 32'h22, 4'b1001, 32'd0);
        tick();
        chk("sq2_valid", 32'(out_valid), 32'd0);
        chk("sq2_nzcv", 32'(nzcv), 32'b0110);
        drv(2'd0, 6'd4, 4'hE, 1'b0, 4'd4, 32'h99, 4'b0000, 32'd0);
        tick();
        chk("post_sq_valid", 32'(out_valid), 32'd1);
        chk("post_sq_wb_en", 32'(wb_en), 32'd1);
        chk("post_sq_wb_rd", 32'(wb_rd), 32'd4);
        chk("post_sq_wb_data", wb_data, 32'h99);

        // Condition failures: NE with Z=1, then never
        drv(2'd0, 6'd4, 4'h1, 1'b1, 4'd3, 32'h5, 4'b0000, 32'd0);
        tick();
        chk("ne_valid", 32'(out_valid), 32'd1);
        chk("ne_wb_en", 32'(wb_en), 32'd0);
        chk("ne_nzcv", 32'(nzcv), 32'b0110);
        drv(2'd0, 6'd4, 4'hF, 1'b1, 4'd3, 32'h5, 4'b0000, 32'd0);
        tick();
        chk("nv_valid", 32'(out_valid), 32'd1);
        chk("nv_wb_en", 32'(wb_en), 32'd0);
        chk("nv_nzcv", 32'(nzcv), 32'b0110);

        // Invalid op produces no request
        drv(2'd3, 6'd4, 4'hE, 1'b1, 4'd3, 32'h5, 4'b1111, 32'd0);
        tick();
        chk("inv_wb_en", 32'(wb_en), 32'd0);
        chk("inv_mem_en", 32'(mem_en), 32'd0);
        chk("inv_br", 32'(br_taken), 32'd0);
        chk("inv_nzcv", 32'(nzcv), 32'b0110);

        // Backpressure
        drv(2'd0, 6'd4, 4'hE, 1'b0, 4'd5, 32'h11, 4'b0000, 32'd0);
        tick();
        chk("bp_first", wb_data, 32'h11);
        out_ready = 1'b0;
        drv(2'd0, 6'd4, 4'hE, 1'b0, 4'd6, 32'h22, 4'b0000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_data", wb_data, 32'h11);
            chk("bp_hold_rd", 32'(wb_rd), 32'd5);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_data", wb_data, 32'h22);
        chk("bp_next_rd", 32'(wb_rd), 32'd6);
        drv(2'd0, 6'd4, 4'hE, 1'b0, 4'd7, 32'h33, 4'b0000, 32'd0);
        tick();
        chk("bp_nobubble", wb_data, 32'h33);
        chk("bp_nobubble_v", 32'(out_valid), 32'd1);

        // Load and store
        drv(2'd1, 6'h19, 4'hE, 1'b0, 4'd5, 32'h100, 4'b0000, 32'hABCD);
        tick();
        chk("ld_mem_en", 32'(mem_en), 32'd1);
        chk("ld_mem_we", 32'(mem_we), 32'd0);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_wb_en", 32'(wb_en), 32'd1);
        chk("ld_wb_rd", 32'(wb_rd), 32'd5);
        chk("ld_wb_data", wb_data, 32'd0);
        drv(2'd1, 6'h18, 4'hE, 1'b0, 4'd6, 32'h104, 4'b0000, 32'hDEAD);
        tick();
        chk("st_mem_en", 32'(mem_en), 32'd1);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h104);
        chk("st_wdata", mem_wdata, 32'hDEAD);
        chk("st_wb_en", 32'(wb_en), 32'd0);

        // Idle drains output
        in_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Reset while holding a stalled entry
        out_ready = 1'b0;
        drv(2'd0, 6'd4, 4'hE, 1'b0, 4'd1, 32'h55, 4'b0000, 32'd0);
        tick();
        chk("pre_rst_data", wb_data, 32'h55);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
        chk("mid_rst_nzcv", 32'(nzcv), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_commit_stage.md
Name: alu_commit_stage

Overview:
Execute-to-writeback stage directly downstream of the ALU. It registers the ALU result and NZCV flags and holds the architectural NZCV register. It evaluates each instruction's 4-bit condition field against that register, then issues register-writeback, memory or branch requests to the next stage over a valid/ready handshake. After a taken branch it squashes the wrong-path instructions already in flight.

Parameters:
SQUASH_SLOTS, 2, number of accepted instructions discarded after a taken branch is accepted (1..7)
DATA_W, 32, datapath width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_op  in  2  0 data, 1 memory, 2 branch, 3 invalid
in_cmd  in  6  data: 0 AND, 1 XOR, 2 SUB, 3 RSB, 4 ADD, 10 CMP, 12 ORR; memory: cmd[0]=1 load, cmd[0]=0 store
in_cond  in  4  ARM condition code
in_s  in  1  set-flags bit
in_rd  in  4  destination register
in_result  in  DATA_W  ALU result (data value, memory address or branch target)
in_flag  in  4  ALU flags, N3 Z2 C1 V0
in_store_data  in  DATA_W  store data
out_valid  out  1  output request valid
out_ready  in  1  downstream accepts
wb_en  out  1  register write request
wb_rd  out  4  write register
wb_data  out  DATA_W  write value
mem_en  out  1  memory access request
mem_we  out  1  1 store, 0 load
mem_addr  out  DATA_W  address
mem_wdata  out  DATA_W  store data
br_taken  out  1  branch redirect
br_target  out  DATA_W  redirect address
nzcv  out  4  architectural flags

Behaviour:
- Reset clears all outputs, nzcv, the squash counter and the state to 0/RUN. A reset asserted mid-transfer drops the held entry.
- Handshake: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready. Latency from accept to out_valid is 1 cycle. Output fields hold stable while out_valid && !out_ready.
- Condition check uses the registered nzcv, which includes updates from the instruction accepted in the previous cycle. Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never.
- Condition fail: the instruction is accepted and produces an output with out_valid=1 and all of wb_en, mem_en and br_taken at 0. Flags are unchanged.
- Flag update on accept, only when the condition passes, op=0, and (in_s=1 or cmd=10):
  - SUB, RSB, ADD, CMP load all four flags.
  - AND, XOR, ORR load N and Z only; C and V are kept.
- Request generation when the condition passes:
  - Data op (except CMP): wb_en=1, wb_rd=in_rd, wb_data=in_result.
  - CMP: no writeback.
  - Memory op: mem_en=1, mem_we=!cmd[0], mem_addr=in_result, mem_wdata=in_store_data. A load also sets wb_en=1 with wb_rd=in_rd; wb_data is don't-care and is driven 0.
  - Branch op: br_taken=1, br_target=in_result.
  - op=3, or an undefined data cmd: no request, no flag change.
- State machine:
  - RUN: an accepted taken branch loads the squash counter with SQUASH_SLOTS and moves to SQUASH.
  - SQUASH: every accept decrements the counter. A squashed instruction produces no output (out_valid falls, or stays 0 after the current output drains), causes no flag update, and can never branch. At count 0 the state returns to RUN. Cycles without in_valid do not decrement.
- Simultaneous events:
  - out_ready and an accept in the same cycle: the held entry retires and the new one loads (full throughput).
  - A branch accepted while out_valid is stalled: the branch waits in the input; no accept happens until in_ready.

Decomposition:
- Shared package: op encodings (OP_DATA/OP_MEM/OP_BR), cmd encodings (CMD_AND..CMD_ORR), condition codes COND_EQ..COND_NV, flag bit indices N=3 Z=2 C=1 V=0.
- One natural sub-module: cond_check, combinational (cond, nzcv -> pass), reused later by fetch-side predication.

Test Plan:
- Reset mid-stream: out_valid=1 holding wb_data=0x55, assert reset -> all outputs 0 immediately, nzcv=0, in_ready=1.
- CMP then branch: CMP result 0, flags Z=1 C=1 (0100b + C), then BEQ target 0x40 on the next cycle -> BEQ sees the updated Z and gives br_taken=1, br_target=0x40; the next 2 accepted instructions (ADD r1, SUB r2) produce no output and no flag change; the third writes back.
- Logic flags: nzcv=0011, ANDS result 0x80000000 -> nzcv=1011; C and V preserved.
- Condition fail: cond=NE with Z=1, ADDS r3, flags 0000 -> out_valid=1, wb_en=0, nzcv unchanged; cond=F behaves the same.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> the next entry loads the same cycle, no bubble.
- Memory: load, cmd=0x19 (cmd[0]=1), addr 0x100, rd=5 -> mem_en=1, mem_we=0, wb_en=1, wb_rd=5; store, cmd=0x18 -> mem_we=1, mem_wdata=in_store_data, wb_en=0.
